// File: rtl/fb_pkg.sv
// Framebuffer package: geometry, word/address types and write-arbiter FSM states.
package fb_pkg;

  localparam int FB_W         = 320;
  localparam int FB_H         = 240;
  localparam int FB_WORDS     = FB_W * FB_H;
  localparam int FB_ADDR_BITS = $clog2(FB_WORDS);

  typedef logic [11:0]             pixel_t;
  typedef logic [FB_ADDR_BITS-1:0] fb_addr_t;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } fbw_state_t;

  // Width of an index able to name any of n writers (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fb_write_arb_if.sv
// Writer request bus plus framebuffer RAM port A.
// master = writer/RAM side, slave = fb_write_arb.
interface fb_write_arb_if #(
  parameter int NUM_REQ   = 2,
  parameter int DATA_BITS = 12,
  parameter int ADDR_BITS = 17
);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*ADDR_BITS-1:0] req_addr;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic                         ram_we;
  logic [ADDR_BITS-1:0]         ram_addr;
  logic [DATA_BITS-1:0]         ram_wdata;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/fb_write_arb_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted index and
// wraps; the pointer only moves when the grant is actually consumed.
module rr_arbiter
  import fb_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = idx_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     i_req,
  input  logic             i_advance,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx
);

  logic [IDX_W-1:0] r_ptr;

  // First requester after the pointer, wrapping modulo N.
  always_comb begin
    logic found;
    int   idx;
    found     = 1'b0;
    idx       = 0;
    o_gnt     = '0;
    o_gnt_idx = '0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(r_ptr) + off) % N;
      if (!found && i_req[idx]) begin
        found      = 1'b1;
        o_gnt[idx] = 1'b1;
        o_gnt_idx  = IDX_W'(idx);
      end
    end
  end

  // Pointer starts at N-1 so writer 0 wins first; moves on a transfer only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= IDX_W'(N - 1);
    end else if (i_advance) begin
      r_ptr <= o_gnt_idx;
    end
  end

endmodule

// File: rtl/fb_write_arb.sv
// Framebuffer port-A write arbiter with built-in clear engine.
// Optional feature macro FB_WR_CLIP_EN: drop out-of-range writes and pulse clip_err.
module fb_write_arb #(
  parameter int NUM_REQ   = 2,
  parameter int DATA_BITS = 12,
  parameter int FB_WORDS  = fb_pkg::FB_WORDS,
  parameter int ADDR_BITS = $clog2(FB_WORDS)
) (
  input  logic                     clk,
  input  logic                     rst,
  fb_write_arb_if.slave            bus,
  input  logic                     clear_start,
  input  logic [DATA_BITS-1:0]     clear_color,
  output logic                     clear_busy,
  output logic [$clog2(NUM_REQ):0] grant_id
`ifdef FB_WR_CLIP_EN
  ,
  output logic                     clip_err
`endif
);

  import fb_pkg::*;

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int GID_W = $clog2(NUM_REQ) + 1;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(FB_WORDS - 1);

  fbw_state_t           r_state;
  logic                 r_we;
  logic [ADDR_BITS-1:0] r_addr;
  logic [DATA_BITS-1:0] r_wdata;
  logic                 r_busy;
  logic [GID_W-1:0]     r_gid;
  logic [ADDR_BITS-1:0] r_cnt;
  logic [DATA_BITS-1:0] r_color;

  logic [NUM_REQ-1:0]   w_gnt;
  logic [IDX_W-1:0]     w_gnt_idx;
  logic                 w_accept_en;
  logic                 w_xfer;
  logic [ADDR_BITS-1:0] w_addr_arr [NUM_REQ];
  logic [DATA_BITS-1:0] w_data_arr [NUM_REQ];
  logic [ADDR_BITS-1:0] w_sel_addr;
  logic [DATA_BITS-1:0] w_sel_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_addr_arr[gi] = bus.req_addr[gi*ADDR_BITS +: ADDR_BITS];
      assign w_data_arr[gi] = bus.req_data[gi*DATA_BITS +: DATA_BITS];
    end
  endgenerate

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .i_req     (bus.req_valid),
    .i_advance (w_xfer),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  // Writers are only served in IDLE, and a clear request beats them.
  assign w_accept_en   = (r_state == ST_IDLE) && !clear_start;
  assign bus.req_ready = w_gnt & {NUM_REQ{w_accept_en}};
  assign w_xfer        = |(bus.req_valid & bus.req_ready);
  assign w_sel_addr    = w_addr_arr[w_gnt_idx];
  assign w_sel_data    = w_data_arr[w_gnt_idx];

`ifdef FB_WR_CLIP_EN
  logic w_in_range;
  logic r_clip;
  assign w_in_range = {1'b0, w_sel_addr} < (ADDR_BITS+1)'(FB_WORDS);
  assign clip_err   = r_clip;

  // Out-of-range pulse follows the accepted transfer by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clip <= 1'b0;
    end else begin
      r_clip <= (r_state == ST_IDLE) && w_xfer && !w_in_range;
    end
  end
`else
  logic w_in_range;
  assign w_in_range = 1'b1;
`endif

  assign bus.ram_we    = r_we;
  assign bus.ram_addr  = r_addr;
  assign bus.ram_wdata = r_wdata;
  assign clear_busy    = r_busy;
  assign grant_id      = r_gid;

  // Clear FSM and registered RAM port: one write per cycle, either a granted
  // writer (IDLE) or the next clear address (CLEAR).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_gid   <= '0;
      r_cnt   <= '0;
      r_color <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_busy <= clear_start;
          if (clear_start) begin
            r_state <= ST_CLEAR;
            r_color <= clear_color;
            r_cnt   <= '0;
            r_we    <= 1'b0;
          end else begin
            r_we <= w_xfer && w_in_range;
            if (w_xfer) begin
              r_addr  <= w_sel_addr;
              r_wdata <= w_sel_data;
              r_gid   <= GID_W'(w_gnt_idx);
            end
          end
        end
        ST_CLEAR: begin
          // busy stays up through the cycle the last clear word is on the port
          r_busy  <= 1'b1;
          r_we    <= 1'b1;
          r_addr  <= r_cnt;
          r_wdata <= r_color;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST_ADDR) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_arb.sv
// Scoreboard bench for fb_write_arb: a cycle-level model predicts ready,
// busy and the RAM write stream; a separate monitor checks the RAM port.
module tb_fb_write_arb;

  localparam int NUM_REQ   = 2;
  localparam int DATA_BITS = 12;
  localparam int FB_WORDS  = 1200;
  localparam int ADDR_BITS = 17;
  localparam int GID_W     = $clog2(NUM_REQ) + 1;
  localparam int P         = 10;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 clear_start;
  logic [DATA_BITS-1:0] clear_color;
  logic                 clear_busy;
  logic [GID_W-1:0]     grant_id;
`ifdef FB_WR_CLIP_EN
  logic                 clip_err;
`endif

  always #(P/2) clk = ~clk;

  fb_write_arb_if #(.NUM_REQ(NUM_REQ), .DATA_BITS(DATA_BITS), .ADDR_BITS(ADDR_BITS)) bus ();

  fb_write_arb #(
    .NUM_REQ   (NUM_REQ),
    .DATA_BITS (DATA_BITS),
    .FB_WORDS  (FB_WORDS),
    .ADDR_BITS (ADDR_BITS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .grant_id    (grant_id)
`ifdef FB_WR_CLIP_EN
    ,
    .clip_err    (clip_err)
`endif
  );

  typedef struct {
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] data;
    int                   gid;
    bit                   is_clear;
    time                  due;
  } exp_t;

  exp_t exp_q[$];
  time  clip_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // writer-side state and reference model state
  bit                   pend   [NUM_REQ];
  logic [ADDR_BITS-1:0] p_addr [NUM_REQ];
  logic [DATA_BITS-1:0] p_data [NUM_REQ];
  int                   last_gnt;
  int                   clr_left;
  bit                   busy_tail;

  function automatic void chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endfunction

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_valid[i] = pend[i];
      bus.req_addr[i*ADDR_BITS +: ADDR_BITS] = p_addr[i];
      bus.req_data[i*DATA_BITS +: DATA_BITS] = p_data[i];
    end
  endtask

  task automatic push_write(input int g, input time t);
    exp_t e;
    e.addr = p_addr[g]; e.data = p_data[g]; e.gid = g; e.is_clear = 1'b0; e.due = t;
`ifdef FB_WR_CLIP_EN
    if (int'(p_addr[g]) >= FB_WORDS) clip_q.push_back(t);
    else exp_q.push_back(e);
`else
    exp_q.push_back(e);
`endif
  endtask

  // One clock cycle: drive, predict ready/busy, then commit the model's decision.
  task automatic cycle(input bit cs, input logic [DATA_BITS-1:0] cc, input bit rnd);
    logic [NUM_REQ-1:0] exp_rdy;
    int  g;
    time t;
    bit  bt;
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    if (rnd) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend[i] && $urandom_range(0, 3) != 0) begin
          pend[i]   = 1'b1;
          p_addr[i] = ($urandom_range(0, 15) == 0) ? ADDR_BITS'(FB_WORDS + $urandom_range(0, 20))
                                                   : ADDR_BITS'($urandom_range(0, FB_WORDS - 1));
          p_data[i] = DATA_BITS'($urandom);
        end
      end
    end
    drive();
    clear_start = cs;
    clear_color = cc;
    #1;
    exp_rdy = '0;
    g = -1;
    if (clr_left == 0 && !cs) begin
      for (int off = 1; off <= NUM_REQ; off++) begin
        int k;
        k = (last_gnt + off) % NUM_REQ;
        if (g < 0 && pend[k]) g = k;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("clear_busy", clear_busy, (clr_left > 0) || busy_tail);
    @(posedge clk);
    t  = $time;
    bt = (clr_left == 1);
    if (clr_left > 0) begin
      clr_left--;
    end else if (cs) begin
      clr_left = FB_WORDS;
      for (int k = 0; k < FB_WORDS; k++) begin
        e.addr = ADDR_BITS'(k); e.data = cc; e.gid = 0; e.is_clear = 1'b1;
        e.due  = t + time'((k + 1) * P);
        exp_q.push_back(e);
      end
      $display("clear start colour=%03h at %0t", cc, t);
    end else if (g >= 0) begin
      push_write(g, t);
      pend[g]  = 1'b0;
      last_gnt = g;
    end
    busy_tail = bt;
  endtask

  // Synchronous reset: everything not yet on the RAM port is dropped.
  task automatic do_reset();
    time t;
    @(negedge clk);
    rst = 1'b1;
    clear_start = 1'b0;
    drive();
    @(posedge clk);
    t = $time;
    while (exp_q.size() > 0 && exp_q[$].due >= t) void'(exp_q.pop_back());
    while (clip_q.size() > 0 && clip_q[$] >= t) void'(clip_q.pop_back());
    last_gnt  = NUM_REQ - 1;
    clr_left  = 0;
    busy_tail = 1'b0;
    #1;
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_wdata", bus.ram_wdata, 0);
    chk("rst_clear_busy", clear_busy, 0);
    chk("rst_grant_id", grant_id, 0);
  endtask

  // Monitor: every RAM-port write must match the head of the scoreboard at its due edge.
  always @(negedge clk) begin : mon
    time  now;
    exp_t e;
    now = $time - P/2;
    while (exp_q.size() > 0 && exp_q[0].due < now) begin
      n_cmp++; n_err++;
      $display("FAIL missing_write actual=none required=addr %0h due %0t", exp_q[0].addr, exp_q[0].due);
      void'(exp_q.pop_front());
    end
    if (bus.ram_we === 1'b1) begin
      if (exp_q.size() == 0 || exp_q[0].due != now) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_write actual=addr %0h data %0h required=no write at %0t",
                 bus.ram_addr, bus.ram_wdata, now);
      end else begin
        e = exp_q.pop_front();
        chk("ram_addr", bus.ram_addr, e.addr);
        chk("ram_wdata", bus.ram_wdata, e.data);
        if (!e.is_clear) begin
          chk("grant_id", grant_id, e.gid);
          $display("write writer=%0d addr=%0h data=%03h at %0t", e.gid, e.addr, e.data, now);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].due == now) begin
      n_cmp++; n_err++;
      $display("FAIL missing_write actual=ram_we 0 required=addr %0h at %0t", exp_q[0].addr, now);
      void'(exp_q.pop_front());
    end
`ifdef FB_WR_CLIP_EN
    if (clip_err === 1'b1) begin
      if (clip_q.size() == 0 || clip_q[0] != now) begin
        n_cmp++; n_err++;
        $display("FAIL clip_err actual=1 required=0 at %0t", now);
      end else begin
        n_cmp++;
        void'(clip_q.pop_front());
        $display("clip pulse at %0t", now);
      end
    end else if (clip_q.size() > 0 && clip_q[0] <= now) begin
      n_cmp++; n_err++;
      $display("FAIL clip_err actual=0 required=1 at %0t", now);
      void'(clip_q.pop_front());
    end
`endif
  end

  task automatic set_req(input int i, input int a, input int d);
    pend[i]   = 1'b1;
    p_addr[i] = ADDR_BITS'(a);
    p_data[i] = DATA_BITS'(d);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((pend[0] || pend[1] || clr_left > 0) && n < limit) begin
      cycle(1'b0, '0, 1'b0);
      n++;
    end
    chk("drain_bound", (pend[0] || pend[1] || clr_left > 0), 0);
  endtask

  initial begin
    rst = 1'b1;
    clear_start = 1'b0;
    clear_color = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend[i] = 1'b0; p_addr[i] = '0; p_data[i] = '0;
    end
    drive();
    last_gnt = NUM_REQ - 1; clr_left = 0; busy_tail = 1'b0;

    do_reset();

    // single write from writer 0
    set_req(0, 5, 12'hF00);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);

    // both writers continuously valid
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!pend[i]) set_req(i, 100 + 2*n + i, $urandom);
      cycle(1'b0, '0, 1'b0);
    end
    drain(8);

    // clear while writer 1 waits; a second start mid-sweep is ignored
    set_req(1, 321, 12'hABC);
    cycle(1'b1, 12'h00F, 1'b0);
    for (int n = 0; n < FB_WORDS + 4 && clr_left > 0; n++)
      cycle(n == 100, 12'h0F0, 1'b0);
    drain(4);

    // randomized traffic with occasional clears
    for (int n = 0; n < 400; n++)
      cycle($urandom_range(0, 299) == 0, DATA_BITS'($urandom), 1'b1);
    drain(FB_WORDS + 20);

    // reset in the middle of a clear, then writer 0 must win first
    cycle(1'b1, 12'h555, 1'b0);
    repeat (1000) cycle(1'b0, '0, 1'b0);
    do_reset();
    set_req(0, 7, 12'h111);
    set_req(1, 9, 12'h222);
    repeat (3) cycle(1'b0, '0, 1'b0);
    drain(4);

    // boundary address: first out-of-range word
    set_req(0, FB_WORDS, 12'h123);
    cycle(1'b0, '0, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b0);

    chk("scoreboard_empty", exp_q.size(), 0);
    chk("clip_queue_empty", clip_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
